// File: rtl/panel_pkg.sv
// Shared types and index constants for the PDP-8 front-panel controller.
package panel_pkg;

  // Control FSM states
  typedef enum logic [2:0] {
    ST_HALTED    = 3'd0,
    ST_RUNNING   = 3'd1,
    ST_HALT_PEND = 3'd2,
    ST_STEP_M    = 3'd3,
    ST_STEP_I    = 3'd4
  } panel_state_e;

  // Switch indices into the debounced press vector
  localparam int unsigned NUM_SW   = 5;
  localparam int unsigned SW_CLEAR = 0;
  localparam int unsigned SW_RUN   = 1;
  localparam int unsigned SW_HALT  = 2;
  localparam int unsigned SW_STEPM = 3;
  localparam int unsigned SW_STEPI = 4;

  // Lamp row indices (one-hot position in lamp_row)
  localparam int unsigned NUM_ROWS = 3;
  localparam int unsigned ROW_PC   = 0;
  localparam int unsigned ROW_DATA = 1;
  localparam int unsigned ROW_INST = 2;

  // Status row payload: {cpu_run, halt_pend, stepping, lamp_inst[7:0]}
  localparam int unsigned STATUS_W = 11;

endpackage

// File: rtl/sw_debounce.sv
// One panel switch: 2-FF synchroniser, stability counter, press pulse on accepted press.
module sw_debounce #(
  parameter int unsigned DEB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_n,     // raw switch, active-low
  output logic press_p   // one-cycle pulse on accepted released->pressed
);

  localparam int unsigned   CNT_W    = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             acc_q,   acc_d;    // accepted level, 1 = released
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // Count consecutive cycles the synced level differs from the accepted one
  always_comb begin
    sync1_d = sw_n;
    sync2_d = sync1_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    if (sync2_q == acc_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      acc_d   = sync2_q;
      press_d = ~sync2_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, counter and accepted-state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      acc_q   <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      acc_q   <= acc_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_p = press_q;

endmodule

// File: rtl/front_panel_ctrl.sv
// PDP-8 front panel: switch debounce, RUN/HALT/STEP control FSM and lamp row scanner.
module front_panel_ctrl
  import panel_pkg::*;
#(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned DEB_CYCLES  = 50000,
  parameter int unsigned SCAN_CYCLES = 4000
) (
  input  logic                SYSCLK,
  input  logic                RESETn,
  input  logic                sw_CLEAR,
  input  logic                sw_RUN,
  input  logic                sw_HALT,
  input  logic                sw_STEPM,
  input  logic                sw_STEPI,
  input  logic                cpu_mem_done,
  input  logic                cpu_inst_done,
  input  logic [WIDTH-1:0]    lamp_pc,
  input  logic [WIDTH-1:0]    lamp_data,
  input  logic [7:0]          lamp_inst,
  output logic                cpu_clear,
  output logic                cpu_run,
  output logic [NUM_ROWS-1:0] lamp_row,
  output logic [WIDTH-1:0]    lamp_col
);

  localparam int unsigned SCN_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
  localparam logic [SCN_W-1:0] SCN_LAST = SCN_W'(SCAN_CYCLES - 1);

  logic [NUM_SW-1:0] sw_raw;
  logic [NUM_SW-1:0] press;
  logic [NUM_SW-1:0] sel;

  panel_state_e state_q, state_d;
  logic         cpu_clear_q, cpu_clear_d;
  logic         cpu_run_q,   cpu_run_d;

  logic [SCN_W-1:0]    scan_cnt_q, scan_cnt_d;
  logic [NUM_ROWS-1:0] lamp_row_q, lamp_row_d;
  logic [WIDTH-1:0]    lamp_col_q, lamp_col_d;
  logic [STATUS_W-1:0] status;

  assign sw_raw[SW_CLEAR] = sw_CLEAR;
  assign sw_raw[SW_RUN]   = sw_RUN;
  assign sw_raw[SW_HALT]  = sw_HALT;
  assign sw_raw[SW_STEPM] = sw_STEPM;
  assign sw_raw[SW_STEPI] = sw_STEPI;

  for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_deb
    sw_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk     (SYSCLK),
      .rst_n   (RESETn),
      .sw_n    (sw_raw[gi]),
      .press_p (press[gi])
    );
  end

  // Keep only the highest-priority press of the cycle
  always_comb begin
    sel = '0;
    if      (press[SW_CLEAR]) sel[SW_CLEAR] = 1'b1;
    else if (press[SW_HALT])  sel[SW_HALT]  = 1'b1;
    else if (press[SW_RUN])   sel[SW_RUN]   = 1'b1;
    else if (press[SW_STEPI]) sel[SW_STEPI] = 1'b1;
    else if (press[SW_STEPM]) sel[SW_STEPM] = 1'b1;
  end

  // Control FSM next state and CPU gating outputs
  always_comb begin
    state_d     = state_q;
    cpu_clear_d = 1'b0;
    cpu_run_d   = (state_q != ST_HALTED);
    unique case (state_q)
      ST_HALTED: begin
        if      (sel[SW_CLEAR]) cpu_clear_d = 1'b1;
        else if (sel[SW_RUN])   state_d     = ST_RUNNING;
        else if (sel[SW_STEPI]) state_d     = ST_STEP_I;
        else if (sel[SW_STEPM]) state_d     = ST_STEP_M;
      end
      ST_RUNNING: begin
        if (sel[SW_HALT]) state_d = ST_HALT_PEND;
      end
      ST_HALT_PEND: begin
        // A finishing instruction wins over a same-cycle RUN press
        if      (cpu_inst_done) state_d = ST_HALTED;
        else if (sel[SW_RUN])   state_d = ST_RUNNING;
      end
      ST_STEP_M: begin
        if (sel[SW_HALT] || cpu_mem_done) state_d = ST_HALTED;
      end
      ST_STEP_I: begin
        if (sel[SW_HALT] || cpu_inst_done) state_d = ST_HALTED;
      end
      default: state_d = ST_HALTED;
    endcase
  end

  // FSM state and CPU control registers
  always_ff @(posedge SYSCLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= ST_HALTED;
      cpu_clear_q <= 1'b0;
      cpu_run_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_clear_q <= cpu_clear_d;
      cpu_run_q   <= cpu_run_d;
    end
  end

  assign status = {cpu_run_q,
                   state_q == ST_HALT_PEND,
                   (state_q == ST_STEP_M) || (state_q == ST_STEP_I),
                   lamp_inst};

  // Row scanner: rotate the row and load its columns together so no ghosting
  always_comb begin
    scan_cnt_d = scan_cnt_q + SCN_W'(1);
    lamp_row_d = lamp_row_q;
    lamp_col_d = lamp_col_q;
    if (scan_cnt_q == SCN_LAST) begin
      scan_cnt_d = '0;
      lamp_row_d = {lamp_row_q[NUM_ROWS-2:0], lamp_row_q[NUM_ROWS-1]};
      if (lamp_row_d[ROW_PC])        lamp_col_d = lamp_pc;
      else if (lamp_row_d[ROW_DATA]) lamp_col_d = lamp_data;
      else if (lamp_row_d[ROW_INST]) lamp_col_d = WIDTH'(status);
      else                           lamp_col_d = '0;
    end
  end

  // Scan counter and lamp output registers
  always_ff @(posedge SYSCLK or negedge RESETn) begin
    if (!RESETn) begin
      scan_cnt_q <= '0;
      lamp_row_q <= NUM_ROWS'(1);
      lamp_col_q <= '0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      lamp_row_q <= lamp_row_d;
      lamp_col_q <= lamp_col_d;
    end
  end

  assign cpu_clear = cpu_clear_q;
  assign cpu_run   = cpu_run_q;
  assign lamp_row  = lamp_row_q;
  assign lamp_col  = lamp_col_q;

endmodule

// File: tb/tb_front_panel_ctrl.sv
// Bench for front_panel_ctrl: action table, lamp table, corner sequences, random vs model.
module tb_front_panel_ctrl;

  localparam int W    = 12;
  localparam int DEB  = 8;
  localparam int SCAN = 4;
  localparam int HOLD = DEB + 6;

  // bench switch indices
  localparam int I_CLR = 0, I_RUN = 1, I_HLT = 2, I_SM = 3, I_SI = 4;
  // model modes
  localparam int M_HALT = 0, M_RUN = 1, M_HP = 2, M_SM = 3, M_SI = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [4:0]   sw_n = 5'b11111;
  logic         mem_done = 1'b0, inst_done = 1'b0;
  logic [W-1:0] pc = '0, data = '0;
  logic [7:0]   inst = '0;
  logic         cpu_clear, cpu_run;
  logic [2:0]   lamp_row;
  logic [W-1:0] lamp_col;

  int n_cmp = 0, n_fail = 0, clr_cnt = 0;

  always #5 clk = ~clk;

  front_panel_ctrl #(.WIDTH(W), .DEB_CYCLES(DEB), .SCAN_CYCLES(SCAN)) dut (
    .SYSCLK(clk), .RESETn(rst_n),
    .sw_CLEAR(sw_n[0]), .sw_RUN(sw_n[1]), .sw_HALT(sw_n[2]),
    .sw_STEPM(sw_n[3]), .sw_STEPI(sw_n[4]),
    .cpu_mem_done(mem_done), .cpu_inst_done(inst_done),
    .lamp_pc(pc), .lamp_data(data), .lamp_inst(inst),
    .cpu_clear(cpu_clear), .cpu_run(cpu_run),
    .lamp_row(lamp_row), .lamp_col(lamp_col)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cpu_clear) clr_cnt++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press(input int idx);
    sw_n[3'(idx)] = 1'b0;
    run_cycles(HOLD);
    sw_n[3'(idx)] = 1'b1;
    run_cycles(HOLD);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sw_n = 5'b11111; mem_done = 1'b0; inst_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  int           m_mode, m_k;
  bit           m_run, m_clear;
  bit   [4:0]   m_pulse;
  bit           m_acc [5];
  bit           hist [5][10];   // hist[s][k] = raw level sampled k edges ago
  bit   [2:0]   m_row;
  logic [W-1:0] m_col;
  int           prio [5] = '{I_CLR, I_HLT, I_RUN, I_SI, I_SM};

  function automatic int next_mode(input int m, input int w, input bit md, input bit id);
    case (m)
      M_HALT:  return (w == I_RUN) ? M_RUN : (w == I_SI) ? M_SI : (w == I_SM) ? M_SM : M_HALT;
      M_RUN:   return (w == I_HLT) ? M_HP : M_RUN;
      M_HP:    return id ? M_HALT : ((w == I_RUN) ? M_RUN : M_HP);
      M_SM:    return ((w == I_HLT) || md) ? M_HALT : M_SM;
      M_SI:    return ((w == I_HLT) || id) ? M_HALT : M_SI;
      default: return M_HALT;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = M_HALT; m_k = 0; m_run = 0; m_clear = 0; m_pulse = '0;
    m_row = 3'b001; m_col = '0;
    for (int s = 0; s < 5; s++) begin
      m_acc[s] = 1'b1;
      for (int k = 0; k < 10; k++) hist[s][k] = 1'b1;
    end
  endtask

  // Advance the model across one clock edge given the inputs seen before it
  task automatic model_edge(input logic [4:0] s_sw, input bit md, input bit id,
                            input logic [W-1:0] s_pc, input logic [W-1:0] s_data,
                            input logic [7:0] s_inst);
    int w;
    bit [4:0] np;
    bit all0, all1;
    w = -1;
    for (int i = 0; i < 5; i++) if (w < 0 && m_pulse[prio[i]]) w = prio[i];
    m_k++;
    if (m_k % SCAN == 0) begin
      case ((m_k / SCAN) % 3)
        0: begin m_row = 3'b001; m_col = s_pc; end
        1: begin m_row = 3'b010; m_col = s_data; end
        default: begin
          m_row = 3'b100;
          m_col = W'({m_run, m_mode == M_HP, (m_mode == M_SM) || (m_mode == M_SI), s_inst});
        end
      endcase
    end
    m_clear = (m_mode == M_HALT) && (w == I_CLR);
    m_run   = (m_mode != M_HALT);
    m_mode  = next_mode(m_mode, w, md, id);
    np = '0;
    for (int s = 0; s < 5; s++) begin
      for (int k = 9; k > 0; k--) hist[s][k] = hist[s][k-1];
      hist[s][0] = s_sw[s];
      all0 = 1'b1; all1 = 1'b1;
      for (int k = 2; k < 2 + DEB; k++) begin
        if (hist[s][k]) all0 = 1'b0; else all1 = 1'b0;
      end
      if (m_acc[s] && all0) begin m_acc[s] = 1'b0; np[s] = 1'b1; end
      else if (!m_acc[s] && all1) m_acc[s] = 1'b1;
    end
    m_pulse = np;
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct { int sw; bit mem; bit inst; bit exp_run; int exp_clr; } act_t;
  typedef struct { logic [W-1:0] pc; logic [W-1:0] data; logic [7:0] inst;
                   logic [2:0] exp_row; logic [W-1:0] exp_col; } lamp_t;

  act_t  acts [18];
  lamp_t lamps [6];

  initial begin
    acts = '{
      '{I_CLR, 0, 0, 0, 1},  // clear in HALTED
      '{I_HLT, 0, 0, 0, 0},  // halt while halted: nothing
      '{I_SI,  0, 0, 1, 0},  // step instruction
      '{-1,    1, 0, 1, 0},  // mem_done ignored in STEP_I
      '{-1,    0, 1, 0, 0},  // inst_done ends step
      '{I_SM,  0, 0, 1, 0},  // step memory cycle
      '{-1,    0, 1, 1, 0},  // inst_done ignored in STEP_M
      '{-1,    1, 0, 0, 0},  // mem_done ends step
      '{I_RUN, 0, 0, 1, 0},  // run
      '{I_CLR, 0, 0, 1, 0},  // clear ignored while running
      '{I_SI,  0, 0, 1, 0},  // step ignored while running
      '{I_HLT, 0, 0, 1, 0},  // halt pending
      '{I_RUN, 0, 0, 1, 0},  // run cancels halt
      '{-1,    0, 1, 1, 0},  // done no longer halts
      '{I_HLT, 0, 0, 1, 0},  // halt pending again
      '{-1,    0, 1, 0, 0},  // done halts
      '{I_SI,  0, 0, 1, 0},  // step
      '{I_HLT, 0, 0, 0, 0}   // halt aborts step
    };
    lamps = '{
      '{12'o7777, 12'o0123, 8'h04, 3'b010, 12'o0123},
      '{12'o7777, 12'o0123, 8'h04, 3'b100, 12'h004},
      '{12'o7777, 12'o0123, 8'h04, 3'b001, 12'o7777},
      '{12'o0000, 12'o5252, 8'h80, 3'b010, 12'o5252},
      '{12'o0000, 12'o5252, 8'h80, 3'b100, 12'h080},
      '{12'o1234, 12'o5252, 8'h01, 3'b001, 12'o1234}
    };

    // reset state
    #12;
    check("rst_run",   32'(cpu_run),   32'd0);
    check("rst_clear", 32'(cpu_clear), 32'd0);
    check("rst_row",   32'(lamp_row),  32'd1);
    check("rst_col",   32'(lamp_col),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // FSM action table
    foreach (acts[i]) begin
      clr_cnt = 0;
      if (acts[i].sw >= 0) press(acts[i].sw);
      if (acts[i].mem || acts[i].inst) begin
        mem_done = acts[i].mem; inst_done = acts[i].inst;
        tick();
        mem_done = 1'b0; inst_done = 1'b0;
        run_cycles(4);
      end
      check($sformatf("act%0d_run", i), 32'(cpu_run), 32'(acts[i].exp_run));
      check($sformatf("act%0d_clr", i), 32'(clr_cnt), 32'(acts[i].exp_clr));
    end

    // bouncing RUN switch: one press, latency 12 cycles from the final edge
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sw_n[I_RUN] = ~sw_n[I_RUN];
      for (int j = 0; j < 3; j++) begin
        tick();
        check("bounce_run", 32'(cpu_run), 32'd0);
      end
    end
    sw_n[I_RUN] = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      check($sformatf("bounce_lat%0d", n), 32'(cpu_run), 32'(n == 12));
    end

    // halt lands on an instruction boundary
    sw_n[I_RUN] = 1'b1;
    run_cycles(HOLD);
    sw_n[I_HLT] = 1'b0;
    run_cycles(19);
    check("halt_wait", 32'(cpu_run), 32'd1);
    inst_done = 1'b1;
    tick();
    inst_done = 1'b0;
    check("halt_done_cyc", 32'(cpu_run), 32'd1);
    tick();
    check("halt_after", 32'(cpu_run), 32'd0);
    sw_n[I_HLT] = 1'b1;
    run_cycles(HOLD);
    clr_cnt = 0;
    press(I_CLR);
    check("halt_is_halted", 32'(clr_cnt), 32'd1);

    // CLEAR and RUN accepted together: clear wins, run dropped
    do_reset();
    clr_cnt = 0;
    sw_n[I_CLR] = 1'b0; sw_n[I_RUN] = 1'b0;
    run_cycles(HOLD);
    sw_n[I_CLR] = 1'b1; sw_n[I_RUN] = 1'b1;
    run_cycles(HOLD);
    check("prio_clr", 32'(clr_cnt), 32'd1);
    check("prio_run", 32'(cpu_run), 32'd0);

    // lamp scan table
    do_reset();
    foreach (lamps[i]) begin
      pc = lamps[i].pc; data = lamps[i].data; inst = lamps[i].inst;
      run_cycles(SCAN);
      check($sformatf("lamp%0d_row", i), 32'(lamp_row), 32'(lamps[i].exp_row));
      check($sformatf("lamp%0d_col", i), 32'(lamp_col), 32'(lamps[i].exp_col));
    end

    // asynchronous reset in the middle of a scan while running
    sw_n[I_RUN] = 1'b0;
    run_cycles(HOLD);
    sw_n[I_RUN] = 1'b1;
    run_cycles(3);
    check("mid_pre_run", 32'(cpu_run), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_row", 32'(lamp_row), 32'd1);
    check("mid_rst_col", 32'(lamp_col), 32'd0);
    check("mid_rst_run", 32'(cpu_run),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // random switches and done pulses against the model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [4:0]   s_sw;
      logic [W-1:0] s_pc, s_data;
      logic [7:0]   s_inst;
      bit           s_md, s_id;
      for (int s = 0; s < 5; s++)
        if ($urandom_range(29, 0) == 0) sw_n[3'(s)] = ~sw_n[3'(s)];
      mem_done  = ($urandom_range(11, 0) == 0);
      inst_done = ($urandom_range(11, 0) == 0);
      pc   = W'($urandom);
      data = W'($urandom);
      inst = 8'(1 << $urandom_range(7, 0));
      s_sw = sw_n; s_md = mem_done; s_id = inst_done;
      s_pc = pc; s_data = data; s_inst = inst;
      tick();
      model_edge(s_sw, s_md, s_id, s_pc, s_data, s_inst);
      check("rnd_run",   32'(cpu_run),   32'(m_run));
      check("rnd_clear", 32'(cpu_clear), 32'(m_clear));
      check("rnd_row",   32'(lamp_row),  32'(m_row));
      check("rnd_col",   32'(lamp_col),  32'(m_col));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
